// File: rtl/fetch_prefetch_queue_pkg.sv
// Shared defaults for the instruction prefetch queue: geometry, reset PC and
// the EMPTY/FILLING/FULL classification of outstanding work.
package fetch_prefetch_queue_pkg;

    localparam int FPQ_DEPTH    = 4;
    localparam int FPQ_AW       = 8;
    localparam int FPQ_DW       = 8;
    localparam int FPQ_CW       = 3;
    localparam int FPQ_RESET_PC = 0;

    typedef enum logic [1:0] {
        FPQ_EMPTY   = 2'd0,
        FPQ_FILLING = 2'd1,
        FPQ_FULL    = 2'd2
    } fpq_state_e;

    // A level counts both stored entries and the read still in flight, so
    // FULL means no further fetch may be issued without risking overflow.
    function automatic fpq_state_e fpqClassify(input int level, input int depth);
        fpq_state_e state;
        if (level == 0) begin
            state = FPQ_EMPTY;
        end else if (level >= depth) begin
            state = FPQ_FULL;
        end else begin
            state = FPQ_FILLING;
        end
        return state;
    endfunction

endpackage

// File: rtl/fetch_prefetch_queue_storage.sv
// Circular register array holding {instruction, pc} entries; the head entry is
// presented straight from the registers so the outputs never see deq/flush.
module fpq_storage
    import fetch_prefetch_queue_pkg::*;
#(
    parameter int DEPTH = FPQ_DEPTH,
    parameter int WIDTH = FPQ_DW + FPQ_AW
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_clear,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_pushData,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_headData
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_head;
    logic [PW-1:0]    r_tail;

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_head <= '0;
            r_tail <= '0;
        end else if (i_clear) begin
            r_head <= '0;
            r_tail <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_tail] <= i_pushData;
                r_tail        <= r_tail + PW'(1);
            end
            if (i_pop) begin
                r_head <= r_head + PW'(1);
            end
        end
    end

    assign o_headData = r_mem[r_head];

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Instruction prefetch queue: runs sequential fetches ahead of IR1, buffers the
// returned words with their PCs, and restarts at the branch target on flush.
module fetch_prefetch_queue
    import fetch_prefetch_queue_pkg::*;
#(
    parameter int DEPTH = FPQ_DEPTH,
    parameter int AW    = FPQ_AW,
    parameter int DW    = FPQ_DW,
    parameter int CW    = FPQ_CW
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          flush,
    input  logic [AW-1:0] flush_pc,
    output logic [AW-1:0] mem_addr,
    output logic          mem_req,
    input  logic [DW-1:0] mem_q,
    input  logic          deq,
    output logic          inst_valid,
    output logic [DW-1:0] inst,
    output logic [AW-1:0] inst_pc,
    output logic [CW-1:0] count
);

    logic [AW-1:0] r_pfPc;
    logic          r_inflight;
    logic [AW-1:0] r_inflightPc;
    logic [CW-1:0] r_occ;

    logic [CW-1:0]    w_level;
    fpq_state_e       w_state;
    logic             w_issue;
    logic             w_push;
    logic             w_pop;
    logic [DW+AW-1:0] w_headData;

    // Issue ignores a same-cycle dequeue so the slot budget never depends on deq.
    assign w_level = r_occ + {{(CW-1){1'b0}}, r_inflight};
    assign w_state = fpqClassify(32'(w_level), DEPTH);
    assign w_issue = !reset && !flush && (w_state != FPQ_FULL);
    assign w_push  = r_inflight && !flush;
    assign w_pop   = deq && (r_occ != '0) && !flush;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pfPc       <= AW'(FPQ_RESET_PC);
            r_inflight   <= 1'b0;
            r_inflightPc <= '0;
            r_occ        <= '0;
        end else if (flush) begin
            r_pfPc     <= flush_pc;
            r_inflight <= 1'b0;
            r_occ      <= '0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_pfPc       <= r_pfPc + AW'(1);
                r_inflightPc <= r_pfPc;
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + CW'(1);
                2'b01:   r_occ <= r_occ - CW'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    fpq_storage #(
        .DEPTH (DEPTH),
        .WIDTH (DW + AW)
    ) uStorage (
        .clock      (clock),
        .reset      (reset),
        .i_clear    (flush),
        .i_push     (w_push),
        .i_pushData ({mem_q, r_inflightPc}),
        .i_pop      (w_pop),
        .o_headData (w_headData)
    );

    assign mem_addr   = r_pfPc;
    assign mem_req    = w_issue;
    assign inst_valid = (r_occ != '0);
    assign inst       = w_headData[DW+AW-1:AW];
    assign inst_pc    = w_headData[AW-1:0];
    assign count      = r_occ;

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Bench for fetch_prefetch_queue: synchronous-read memory model M[i]=0x10+i and
// a scoreboard of expected {inst, pc} words restarted at every redirect.
module tb_fetch_prefetch_queue;

    localparam int DEPTH = 4;
    localparam int AW    = 8;
    localparam int DW    = 8;
    localparam int CW    = 3;

    logic          clock    = 1'b0;
    logic          reset    = 1'b1;
    logic          flush    = 1'b0;
    logic [AW-1:0] flush_pc = '0;
    logic          deq      = 1'b0;
    logic [AW-1:0] mem_addr;
    logic          mem_req;
    logic [DW-1:0] mem_q;
    logic          inst_valid;
    logic [DW-1:0] inst;
    logic [AW-1:0] inst_pc;
    logic [CW-1:0] count;

    logic [DW-1:0] memArr [256];
    logic [15:0]   sbQ [$];
    logic [7:0]    sbNext;
    int            vectors     = 0;
    int            miscompares = 0;

    fetch_prefetch_queue #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW),
        .CW    (CW)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .flush      (flush),
        .flush_pc   (flush_pc),
        .mem_addr   (mem_addr),
        .mem_req    (mem_req),
        .mem_q      (mem_q),
        .deq        (deq),
        .inst_valid (inst_valid),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .count      (count)
    );

    always #5 clock = ~clock;

    // Memory latches the address at the edge and returns the word next cycle.
    always @(posedge clock) mem_q <= memArr[mem_addr];

    // The issue rule must keep the queue from ever being pushed past DEPTH.
    always @(negedge clock) begin
        if (!reset) begin
            vectors++;
            if (count > CW'(DEPTH)) begin
                $display("[TB] FAIL overflow: count=%0d, limit=%0d", count, DEPTH);
                miscompares++;
            end
        end
    end

    task automatic sbPush();
        sbQ.push_back({memArr[sbNext], sbNext});
        sbNext = sbNext + 8'd1;
    endtask

    task automatic sbRestart(input logic [7:0] target);
        sbQ.delete();
        sbNext = target;
        repeat (8) sbPush();
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clock);
        #3;
        vectors++;
        if ({inst_valid, inst, inst_pc, count, mem_req, mem_addr} !== '0) begin
            $display("[TB] FAIL reset_outputs: valid=%b inst=%h pc=%h count=%0d req=%b addr=%h, want all 0",
                     inst_valid, inst, inst_pc, count, mem_req, mem_addr);
            miscompares++;
        end
    endtask

    task automatic test_startup();
        logic [7:0] eAddr  [6] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
        logic       eReq   [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic       eValid [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [2:0] eCount [6] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
        @(posedge clock);
        #2;
        reset = 1'b0;
        sbRestart(8'h00);
        #1;
        for (int c = 0; c < 6; c++) begin
            vectors++;
            if ({inst_valid, count, mem_req, mem_addr} !== {eValid[c], eCount[c], eReq[c], eAddr[c]}) begin
                $display("[TB] FAIL startup_c%0d: valid=%b count=%0d req=%b addr=%h, want valid=%b count=%0d req=%b addr=%h",
                         c + 1, inst_valid, count, mem_req, mem_addr, eValid[c], eCount[c], eReq[c], eAddr[c]);
                miscompares++;
            end
            if (c == 2) begin
                vectors++;
                if ({inst, inst_pc} !== 16'h1000) begin
                    $display("[TB] FAIL startup_head: inst=%h pc=%h, want inst=10 pc=00", inst, inst_pc);
                    miscompares++;
                end
            end
            if (c < 5) begin
                @(posedge clock);
                #3;
            end
        end
    endtask

    task automatic test_continuous_deq();
        logic [15:0] exp;
        logic [2:0]  expCount;
        deq = 1'b1;
        for (int i = 0; i < 12; i++) begin
            expCount = (i == 0) ? 3'd4 : (i == 1) ? 3'd3 : 3'd2;
            vectors++;
            if ({inst_valid, count} !== {1'b1, expCount}) begin
                $display("[TB] FAIL stream_level_%0d: valid=%b count=%0d, want valid=1 count=%0d",
                         i, inst_valid, count, expCount);
                miscompares++;
            end
            if (deq && inst_valid && !flush) begin
                exp = sbQ.pop_front();
                sbPush();
                vectors++;
                if ({inst, inst_pc} !== exp) begin
                    $display("[TB] FAIL stream_word_%0d: inst=%h pc=%h, want inst=%h pc=%h",
                             i, inst, inst_pc, exp[15:8], exp[7:0]);
                    miscompares++;
                end
            end
            @(posedge clock);
            #3;
        end
        deq = 1'b0;
    endtask

    task automatic test_flush_full();
        @(posedge clock);
        #3;
        vectors++;
        if ({count, mem_req} !== {3'd3, 1'b0}) begin
            $display("[TB] FAIL preflush_state: count=%0d req=%b, want count=3 req=0", count, mem_req);
            miscompares++;
        end
        flush    = 1'b1;
        flush_pc = 8'h40;
        #1;
        vectors++;
        if (mem_req !== 1'b0) begin
            $display("[TB] FAIL flush_suppress_issue: req=%b, want 0", mem_req);
            miscompares++;
        end
        @(posedge clock);
        #2;
        flush = 1'b0;
        sbRestart(8'h40);
        #1;
        vectors++;
        if ({inst_valid, count, mem_req, mem_addr} !== {1'b0, 3'd0, 1'b1, 8'h40}) begin
            $display("[TB] FAIL flush_f1: valid=%b count=%0d req=%b addr=%h, want valid=0 count=0 req=1 addr=40",
                     inst_valid, count, mem_req, mem_addr);
            miscompares++;
        end
        @(posedge clock);
        #3;
        vectors++;
        if ({inst_valid, count, mem_req, mem_addr} !== {1'b0, 3'd0, 1'b1, 8'h41}) begin
            $display("[TB] FAIL flush_f2: valid=%b count=%0d req=%b addr=%h, want valid=0 count=0 req=1 addr=41",
                     inst_valid, count, mem_req, mem_addr);
            miscompares++;
        end
        @(posedge clock);
        #3;
        vectors++;
        if ({inst_valid, count, inst, inst_pc} !== {1'b1, 3'd1, sbQ[0]}) begin
            $display("[TB] FAIL flush_f3: valid=%b count=%0d inst=%h pc=%h, want valid=1 count=1 inst=%h pc=%h",
                     inst_valid, count, inst, inst_pc, sbQ[0][15:8], sbQ[0][7:0]);
            miscompares++;
        end
    endtask

    task automatic test_flush_deq_double();
        @(posedge clock);
        #2;
        flush    = 1'b1;
        flush_pc = 8'h60;
        deq      = 1'b1;
        #1;
        vectors++;
        if ({inst_valid, mem_req} !== 2'b10) begin
            $display("[TB] FAIL dbl_f0: valid=%b req=%b, want valid=1 req=0", inst_valid, mem_req);
            miscompares++;
        end
        @(posedge clock);
        #2;
        flush_pc = 8'h80;
        deq      = 1'b0;
        #1;
        vectors++;
        if ({inst_valid, count, mem_req, mem_addr} !== {1'b0, 3'd0, 1'b0, 8'h60}) begin
            $display("[TB] FAIL dbl_f1: valid=%b count=%0d req=%b addr=%h, want valid=0 count=0 req=0 addr=60",
                     inst_valid, count, mem_req, mem_addr);
            miscompares++;
        end
        @(posedge clock);
        #2;
        flush = 1'b0;
        sbRestart(8'h80);
        #1;
        vectors++;
        if ({inst_valid, count, mem_req, mem_addr} !== {1'b0, 3'd0, 1'b1, 8'h80}) begin
            $display("[TB] FAIL dbl_g1: valid=%b count=%0d req=%b addr=%h, want valid=0 count=0 req=1 addr=80",
                     inst_valid, count, mem_req, mem_addr);
            miscompares++;
        end
        @(posedge clock);
        #3;
        vectors++;
        if ({inst_valid, count, mem_req, mem_addr} !== {1'b0, 3'd0, 1'b1, 8'h81}) begin
            $display("[TB] FAIL dbl_g2: valid=%b count=%0d req=%b addr=%h, want valid=0 count=0 req=1 addr=81",
                     inst_valid, count, mem_req, mem_addr);
            miscompares++;
        end
        @(posedge clock);
        #3;
        vectors++;
        if ({inst_valid, count, inst, inst_pc} !== {1'b1, 3'd1, 8'h90, 8'h80}) begin
            $display("[TB] FAIL dbl_g3: valid=%b count=%0d inst=%h pc=%h, want valid=1 count=1 inst=90 pc=80",
                     inst_valid, count, inst, inst_pc);
            miscompares++;
        end
    endtask

    task automatic test_wrap();
        logic [15:0] exp;
        int          got        = 0;
        int          cyc        = 1;
        int          firstValid = 0;
        @(posedge clock);
        #2;
        flush    = 1'b1;
        flush_pc = 8'hFE;
        @(posedge clock);
        #2;
        flush = 1'b0;
        deq   = 1'b1;
        sbRestart(8'hFE);
        #1;
        for (int g = 0; g < 20 && got < 6; g++) begin
            if (got > 0) begin
                vectors++;
                if (inst_valid !== 1'b1) begin
                    $display("[TB] FAIL wrap_gap: valid=%b at cycle %0d, want 1", inst_valid, cyc);
                    miscompares++;
                end
            end
            if (deq && inst_valid && !flush) begin
                if (got == 0) firstValid = cyc;
                exp = sbQ.pop_front();
                sbPush();
                vectors++;
                if ({inst, inst_pc} !== exp) begin
                    $display("[TB] FAIL wrap_word_%0d: inst=%h pc=%h, want inst=%h pc=%h",
                             got, inst, inst_pc, exp[15:8], exp[7:0]);
                    miscompares++;
                end
                got++;
            end
            if (got < 6) begin
                @(posedge clock);
                #3;
                cyc++;
            end
        end
        vectors++;
        if (got != 6) begin
            $display("[TB] FAIL wrap_timeout: consumed %0d words, want 6", got);
            miscompares++;
        end
        vectors++;
        if (firstValid != 3) begin
            $display("[TB] FAIL wrap_latency: first valid at cycle %0d, want 3", firstValid);
            miscompares++;
        end
        @(posedge clock);
        #2;
        deq = 1'b0;
    endtask

    task automatic test_reset_midflight();
        @(posedge clock);
        #2;
        flush    = 1'b1;
        flush_pc = 8'h20;
        @(posedge clock);
        #2;
        flush = 1'b0;
        #1;
        for (int g = 0; g < 10 && count != 3'd3; g++) begin
            @(posedge clock);
            #3;
        end
        vectors++;
        if ({count, mem_req} !== {3'd3, 1'b0}) begin
            $display("[TB] FAIL prereset_state: count=%0d req=%b, want count=3 req=0", count, mem_req);
            miscompares++;
        end
        reset = 1'b1;
        #1;
        vectors++;
        if ({inst_valid, inst, inst_pc, count, mem_req, mem_addr} !== '0) begin
            $display("[TB] FAIL midreset_now: valid=%b inst=%h pc=%h count=%0d req=%b addr=%h, want all 0",
                     inst_valid, inst, inst_pc, count, mem_req, mem_addr);
            miscompares++;
        end
        @(posedge clock);
        #3;
        vectors++;
        if ({inst_valid, inst, inst_pc, count, mem_req, mem_addr} !== '0) begin
            $display("[TB] FAIL midreset_held: valid=%b inst=%h pc=%h count=%0d req=%b addr=%h, want all 0",
                     inst_valid, inst, inst_pc, count, mem_req, mem_addr);
            miscompares++;
        end
        reset = 1'b0;
        deq   = 1'b1;
        #1;
        vectors++;
        if ({inst_valid, count, mem_req, mem_addr} !== {1'b0, 3'd0, 1'b1, 8'h00}) begin
            $display("[TB] FAIL rerun_c1: valid=%b count=%0d req=%b addr=%h, want valid=0 count=0 req=1 addr=00",
                     inst_valid, count, mem_req, mem_addr);
            miscompares++;
        end
        @(posedge clock);
        #3;
        vectors++;
        if ({inst_valid, count, mem_req, mem_addr} !== {1'b0, 3'd0, 1'b1, 8'h01}) begin
            $display("[TB] FAIL rerun_c2: valid=%b count=%0d req=%b addr=%h, want valid=0 count=0 req=1 addr=01",
                     inst_valid, count, mem_req, mem_addr);
            miscompares++;
        end
        @(posedge clock);
        #3;
        vectors++;
        if ({inst_valid, count, inst, inst_pc} !== {1'b1, 3'd1, 8'h10, 8'h00}) begin
            $display("[TB] FAIL rerun_c3: valid=%b count=%0d inst=%h pc=%h, want valid=1 count=1 inst=10 pc=00",
                     inst_valid, count, inst, inst_pc);
            miscompares++;
        end
        deq = 1'b0;
        @(posedge clock);
        #3;
        vectors++;
        if (count !== 3'd2) begin
            $display("[TB] FAIL rerun_c4: count=%0d, want 2", count);
            miscompares++;
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            memArr[i] = 8'(16 + i);
        end
        test_reset();
        test_startup();
        test_continuous_deq();
        test_flush_full();
        test_flush_deq_double();
        test_wrap();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: bench still running at time limit, want finished");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
